if_instr_queue: RTL

//  Fetch-side instruction queue between the IF2 stage (ICache data return) and decode.

---
 rtl/if_instr_queue_pkg.sv | 13 +
 rtl/if_instr_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/if_instr_queue_pkg.sv
// Front-end types and constants shared by the fetch stages and the instruction queue.
package if_instr_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  ecode;
    } fetch_pkt_t;

    localparam logic [7:0]  ECODE_ADEF = 8'b1_000_1000;
    localparam logic [31:0] RESET_PC   = 32'h1c00_0000;

endpackage

// File: rtl/if_instr_queue.sv
// In-order {pc, instr, ecode} queue between IF2 and decode; entries visible 1 cycle after enqueue.
// Decode back-pressure via out_ready; stall_full_instr (registered) holds IF1 with SLACK entries spare.
module if_instr_queue
    import if_instr_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SLACK = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic [7:0]               in_ecode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [7:0]               out_ecode,
    output logic                     stall_full_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_pkt_t      entry [DEPTH];
    fetch_pkt_t      head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            full;
    logic            enq;
    logic            deq;

    assign full = (count_q == CW'(DEPTH));
    assign enq  = in_valid && !full && !flush;
    assign deq  = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({enq, deq})
                2'b10:   count_next = count_q + CW'(1);
                2'b01:   count_next = count_q - CW'(1);
                default: count_next = count_q;
            endcase
        end
    end

    // Storage carries no reset: contents are don't-care while out_valid is low.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry[wr_ptr] <= '{pc: in_pc, instr: in_instr, ecode: in_ecode};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_next;
        end
    end

    // Registered stall, looking at next occupancy so it tracks count without lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_full_instr <= 1'b0;
        end else begin
            stall_full_instr <= !flush && (count_next >= CW'(DEPTH - SLACK));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && full && !flush) begin
            overflow <= 1'b1;
        end
    end

    assign head      = entry[rd_ptr];
    assign out_valid = (count_q != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_ecode = head.ecode;
    assign count     = count_q;

endmodule
